// File: rtl/neuron_par.sv
`default_nettype none
// ============================================================================
// Module      : neuron_par
// Description : LANES-wide multiply-accumulate neuron with biased sum and a
//               clamped ReLU output. Define NEURON_SAT_EN to saturate the
//               accumulator and bias additions instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================

module neuron_par #(
    parameter int NUM_WEIGHT       = 784,
    parameter int DATA_WIDTH       = 8,
    parameter int LANES            = 4,
    parameter int WEIGHT_INT_WIDTH = 4,
    parameter int LAYER_NO         = 1,
    parameter int NEURON_NO        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES*DATA_WIDTH-1:0]   myinput,
    input  logic                          myinputValid,
    input  logic                          weightValid,
    input  logic                          biasValid,
    input  logic [31:0]                   weightValue,
    input  logic [31:0]                   biasValue,
    input  logic [31:0]                   config_layer_num,
    input  logic [31:0]                   config_neuron_num,
    output logic [DATA_WIDTH-1:0]         out,
    output logic                          outvalid,
    output logic [2*DATA_WIDTH-1:0]       sum_o,
    output logic                          busy
);

    localparam int c_PROD_W = 2 * DATA_WIDTH;
    localparam int c_BEATS  = NUM_WEIGHT / LANES;
    localparam int c_AW     = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int c_BW     = $clog2(c_BEATS + 1);
    localparam int c_SHIFT  = DATA_WIDTH - WEIGHT_INT_WIDTH;
    localparam logic [c_PROD_W-1:0] c_OUT_MAX = c_PROD_W'((2 ** (DATA_WIDTH - 1)) - 1);

`ifdef NEURON_SAT_EN
    // Wide enough for a full lane sum plus the accumulator without overflow.
    localparam int c_WIDE = c_PROD_W + $clog2(LANES) + 2;
    localparam logic signed [c_WIDE-1:0] c_SAT_MAX = c_WIDE'({1'b0, {(c_PROD_W-1){1'b1}}});
    localparam logic signed [c_WIDE-1:0] c_SAT_MIN = ~c_SAT_MAX;
`else
    localparam int c_WIDE = c_PROD_W;
`endif

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCUM  = 2'd1;
    localparam logic [1:0] c_ST_FINISH = 2'd2;
    localparam logic [1:0] c_ST_OUT    = 2'd3;

    logic [DATA_WIDTH-1:0]        r_weight_mem [NUM_WEIGHT];
    logic [c_AW-1:0]              r_wptr;
    logic signed [c_PROD_W-1:0]   r_bias;
    logic signed [c_PROD_W-1:0]   r_acc;
    logic signed [c_PROD_W-1:0]   r_sum;
    logic signed [c_PROD_W-1:0]   r_prod [LANES];
    logic signed [c_PROD_W-1:0]   w_prod [LANES];
    logic                         r_prod_vld;
    logic [c_BW-1:0]              r_beat;
    logic [1:0]                   r_state;
    logic [1:0]                   w_state_nxt;
    logic [DATA_WIDTH-1:0]        r_out;
    logic                         r_outvalid;
    logic                         w_cfg_hit;
    logic                         w_busy;
    logic                         w_last_done;
    logic                         w_accept;
    logic                         w_wr_en;
    logic signed [c_WIDE-1:0]     w_lane_sum;
    logic [c_PROD_W-1:0]          w_acc_nxt;
    logic [c_PROD_W-1:0]          w_biased;
    logic                         w_unused;

    function automatic logic signed [c_PROD_W-1:0] mul_s(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [c_PROD_W-1:0] a_ext;
        logic signed [c_PROD_W-1:0] b_ext;
        a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        return a_ext * b_ext;
    endfunction

    function automatic logic [c_PROD_W-1:0] fit(input logic signed [c_WIDE-1:0] v);
`ifdef NEURON_SAT_EN
        if (v > c_SAT_MAX) begin
            return c_SAT_MAX[c_PROD_W-1:0];
        end else if (v < c_SAT_MIN) begin
            return c_SAT_MIN[c_PROD_W-1:0];
        end else begin
            return v[c_PROD_W-1:0];
        end
`else
        return v;
`endif
    endfunction

    // Negative sums clamp to zero; positive ones drop the fraction bits.
    function automatic logic [DATA_WIDTH-1:0] relu_q(input logic signed [c_PROD_W-1:0] s);
        logic [c_PROD_W-1:0] sh;
        sh = s >>> c_SHIFT;
        if (s[c_PROD_W-1]) begin
            return '0;
        end else if (sh > c_OUT_MAX) begin
            return c_OUT_MAX[DATA_WIDTH-1:0];
        end else begin
            return sh[DATA_WIDTH-1:0];
        end
    endfunction

    assign w_cfg_hit   = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
    assign w_busy      = (r_state == c_ST_FINISH) || (r_state == c_ST_OUT);
    assign w_last_done = (r_beat == c_BW'(c_BEATS));
    assign w_accept    = myinputValid &&
                         ((r_state == c_ST_IDLE) || ((r_state == c_ST_ACCUM) && !w_last_done));
    assign w_wr_en     = weightValid && w_cfg_hit && !w_busy;
    assign w_unused    = ^{weightValue[31:DATA_WIDTH], biasValue[31:c_PROD_W]};

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_prod[k] = mul_s(myinput[k*DATA_WIDTH +: DATA_WIDTH],
                              r_weight_mem[c_AW'(int'(r_beat) * LANES + k)]);
        end
    end

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_sum = w_lane_sum + c_WIDE'(r_prod[k]);
        end
        w_acc_nxt = fit(c_WIDE'(r_acc) + w_lane_sum);
        w_biased  = fit(c_WIDE'(r_acc) + c_WIDE'(r_bias));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (myinputValid) w_state_nxt = c_ST_ACCUM;
            c_ST_ACCUM:  if (w_last_done && !r_prod_vld) w_state_nxt = c_ST_FINISH;
            c_ST_FINISH: w_state_nxt = c_ST_OUT;
            c_ST_OUT:    w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Weight storage is intentionally not reset so weights survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_weight_mem[r_wptr] <= weightValue[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_vld <= 1'b0;
            r_beat     <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_out      <= '0;
            r_outvalid <= 1'b0;
            r_bias     <= '0;
            r_wptr     <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            r_prod_vld <= w_accept;
            r_outvalid <= 1'b0;
            if (w_accept) begin
                for (int k = 0; k < LANES; k++) begin
                    r_prod[k] <= w_prod[k];
                end
                r_beat <= r_beat + 1'b1;
            end
            if (r_prod_vld) begin
                r_acc <= w_acc_nxt;
            end
            if (r_state == c_ST_FINISH) begin
                r_sum      <= w_biased;
                r_out      <= relu_q(w_biased);
                r_outvalid <= 1'b1;
                r_acc      <= '0;
                r_beat     <= '0;
            end
            if (w_wr_en) begin
                r_wptr <= (r_wptr == c_AW'(NUM_WEIGHT - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (biasValid && w_cfg_hit && !w_busy) begin
                r_bias <= biasValue[c_PROD_W-1:0];
            end
        end
    end

    assign out      = r_out;
    assign outvalid = r_outvalid;
    assign sum_o    = r_sum;
    assign busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_neuron_par.sv
`default_nettype none
// tb_neuron_par: fixed vector table, corner-case sequences and randomized
// vectors compared against an arithmetic reference model.

module tb_neuron_par;

    localparam int DW  = 8;
    localparam int LN  = 4;
    localparam int NW  = 8;
    localparam int WIF = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [LN*DW-1:0]  myinput;
    logic              myinputValid;
    logic              weightValid;
    logic              biasValid;
    logic [31:0]       weightValue;
    logic [31:0]       biasValue;
    logic [31:0]       config_layer_num;
    logic [31:0]       config_neuron_num;
    logic [DW-1:0]     out;
    logic              outvalid;
    logic [2*DW-1:0]   sum_o;
    logic              busy;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0]  w_vec [NW];
    logic [7:0]  x_vec [NW];
    logic [15:0] last_sum;

    typedef struct {
        logic [7:0]  w;
        logic [7:0]  x;
        logic [15:0] bias;
        logic [15:0] es;
        logic [7:0]  eo;
    } vec_t;

    vec_t tbl [6];

    neuron_par #(
        .NUM_WEIGHT       (NW),
        .DATA_WIDTH       (DW),
        .LANES            (LN),
        .WEIGHT_INT_WIDTH (WIF),
        .LAYER_NO         (1),
        .NEURON_NO        (0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .myinput           (myinput),
        .myinputValid      (myinputValid),
        .weightValid       (weightValid),
        .biasValid         (biasValid),
        .weightValue       (weightValue),
        .biasValue         (biasValue),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .out               (out),
        .outvalid          (outvalid),
        .sum_o             (sum_o),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint fixw(input longint v);
`ifdef NEURON_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic signed [15:0] t;
        t = v[15:0];
        return t;
`endif
    endfunction

    // Dot product per beat, bias added last, then ReLU and fixed-point rescale.
    task automatic ref_model(input logic [15:0] bias, output logic [15:0] s, output logic [7:0] o);
        longint acc;
        longint ls;
        int     wi;
        int     xi;
        int     bi;
        acc = 0;
        for (int b = 0; b < NW / LN; b++) begin
            ls = 0;
            for (int l = 0; l < LN; l++) begin
                wi = $signed(w_vec[b*LN+l]);
                xi = $signed(x_vec[b*LN+l]);
                ls = ls + wi * xi;
            end
            acc = fixw(acc + ls);
        end
        bi  = $signed(bias);
        acc = fixw(acc + bi);
        s = acc[15:0];
        if (acc < 0)             o = 8'h00;
        else if (acc / 16 > 127) o = 8'h7F;
        else                     o = 8'(acc / 16);
    endtask

    task automatic load_weights();
        logic [31:0] t;
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            t = $urandom();
            t[7:0] = w_vec[i];
            weightValue       = t;
            weightValid       = 1'b1;
            config_layer_num  = 32'd1;
            config_neuron_num = 32'd0;
        end
        @(negedge clk);
        weightValid = 1'b0;
    endtask

    task automatic load_bias(input logic [15:0] b);
        logic [31:0] t;
        @(negedge clk);
        t = $urandom();
        t[15:0] = b;
        biasValue = t;
        biasValid = 1'b1;
        @(negedge clk);
        biasValid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [15:0] es, input logic [7:0] eo,
                           input int gap, input bit poke);
        int lat;
        for (int b = 0; b < NW / LN; b++) begin
            @(negedge clk);
            if (b > 0 && gap > 0) begin
                myinputValid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            for (int l = 0; l < LN; l++) myinput[l*DW +: DW] = x_vec[b*LN+l];
            myinputValid = 1'b1;
        end
        @(posedge clk);
        #1;
        lat = 1;
        @(negedge clk);
        myinputValid = 1'b0;
        while (outvalid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 3) begin
                check({tag, "_busy_in_finish"}, 32'(busy), 32'd1);
                myinput           = $urandom();
                myinputValid      = 1'b1;
                weightValue       = 32'h0000_007F;
                weightValid       = 1'b1;
                biasValue         = 32'h0000_7FFF;
                biasValid         = 1'b1;
                config_layer_num  = 32'd1;
                config_neuron_num = 32'd0;
            end
        end
        myinputValid = 1'b0;
        weightValid  = 1'b0;
        biasValid    = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum_o"}, 32'(sum_o), 32'(es));
        check({tag, "_out"}, 32'(out), 32'(eo));
        check({tag, "_busy_in_out"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse_width"}, 32'(outvalid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        last_sum = es;
    endtask

    initial begin
        int          cnt;
        logic [15:0] es;
        logic [7:0]  eo;
        logic [15:0] bias;

        rst               = 1'b1;
        myinput           = '0;
        myinputValid      = 1'b0;
        weightValid       = 1'b0;
        biasValid         = 1'b0;
        weightValue       = '0;
        biasValue         = '0;
        config_layer_num  = 32'd1;
        config_neuron_num = 32'd0;
        last_sum          = '0;

        tbl[0] = '{8'h10, 8'h02, 16'h0000, 16'h0100, 8'h10};
        tbl[1] = '{8'h10, 8'h02, 16'hFE00, 16'hFF00, 8'h00};
`ifdef NEURON_SAT_EN
        tbl[2] = '{8'h7F, 8'h7F, 16'h0000, 16'h7FFF, 8'h7F};
`else
        tbl[2] = '{8'h7F, 8'h7F, 16'h0000, 16'hF808, 8'h00};
`endif
        tbl[3] = '{8'hF0, 8'h02, 16'h0000, 16'hFF00, 8'h00};
        tbl[4] = '{8'h20, 8'h10, 16'h0000, 16'h1000, 8'h7F};
        tbl[5] = '{8'h10, 8'h05, 16'h0030, 16'h02B0, 8'h2B};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_outvalid", 32'(outvalid), 32'd0);
        check("reset_sum_o", 32'(sum_o), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < NW; j++) begin
                w_vec[j] = tbl[i].w;
                x_vec[j] = tbl[i].x;
            end
            load_weights();
            load_bias(tbl[i].bias);
            run_vec($sformatf("tbl%0d", i), tbl[i].es, tbl[i].eo, i % 2, 1'b0);
        end

        // Mis-addressed writes and writes while busy must not touch RAM/bias.
        for (int j = 0; j < NW; j++) begin
            w_vec[j] = 8'h10;
            x_vec[j] = 8'h02;
        end
        load_weights();
        load_bias(16'h0000);
        @(negedge clk);
        weightValue       = 32'h0000_0055;
        weightValid       = 1'b1;
        config_neuron_num = 32'd1;
        @(negedge clk);
        config_neuron_num = 32'd0;
        config_layer_num  = 32'd2;
        biasValue         = 32'h0000_1234;
        biasValid         = 1'b1;
        @(negedge clk);
        weightValid       = 1'b0;
        biasValid         = 1'b0;
        config_layer_num  = 32'd1;
        run_vec("cfg_poke", 16'h0100, 8'h10, 0, 1'b1);
        run_vec("after_poke", 16'h0100, 8'h10, 0, 1'b0);

        // Reset after the first beat abandons the vector.
        @(negedge clk);
        for (int l = 0; l < LN; l++) myinput[l*DW +: DW] = 8'h02;
        myinputValid = 1'b1;
        @(negedge clk);
        myinputValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (outvalid === 1'b1) cnt++;
        end
        check("rst_mid_no_outvalid", 32'(cnt), 32'd0);
        check("rst_mid_sum_o", 32'(sum_o), 32'd0);
        last_sum = '0;
        run_vec("after_rst", 16'h0100, 8'h10, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < NW; j++) begin
                w_vec[j] = 8'($urandom_range(0, 255));
                x_vec[j] = 8'($urandom_range(0, 255));
            end
            bias = 16'($urandom());
            if (i % 4 == 0) bias = 16'($urandom_range(0, 255));
            load_weights();
            load_bias(bias);
            check($sformatf("rnd%0d_hold_sum", i), 32'(sum_o), 32'(last_sum));
            ref_model(bias, es, eo);
            run_vec($sformatf("rnd%0d", i), es, eo, int'($urandom_range(0, 2)), 1'(i % 3 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
